// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B pixel feeder.
// Optional macro WS2812B_PIXEL_REPEAT_EN adds a per-entry repeat count to the entry type.
package ws2812b_pkg;

    localparam int DEFAULT_DEPTH = 4;

    // Position of each colour byte within a three-byte pixel write
    localparam logic [1:0] BYTE_G = 2'd0;
    localparam logic [1:0] BYTE_R = 2'd1;
    localparam logic [1:0] BYTE_B = 2'd2;

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        pixel_t     pixel;
        logic       latch;
`ifdef WS2812B_PIXEL_REPEAT_EN
        logic [7:0] rpt;
`endif
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ws2812b_sync_fifo.sv
// Generic DEPTH x WIDTH register FIFO. The head entry is read combinationally
// from storage, so it is visible the cycle after it is pushed. Clear resets
// pointers and level only; storage is cleared by rst_n alone.
module ws2812b_sync_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int WIDTH  = 25,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [LVL_W-1:0] level,
    output logic             full
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign pop_ok    = pop && (level != '0);
    assign push_ok   = push && ((level != FULL_LVL) || pop_ok);
    assign full      = (level == FULL_LVL);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; clear takes priority over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ws2812b_pixel_fifo.sv
// Byte-bus to WS2812B driver feeder: assembles G,R,B byte writes into pixels,
// queues them with a latch flag and presents the head to the serial driver.
// Optional macro WS2812B_PIXEL_REPEAT_EN: each entry is shown wr_repeat+1 times.
module ws2812b_pixel_fifo
    import ws2812b_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             wr_latch,
`ifdef WS2812B_PIXEL_REPEAT_EN
    input  logic [7:0]       wr_repeat,
`endif
    input  logic             clear,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    output logic             pix_latch,
    input  logic             pix_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             fifo_full,
    output logic             overflow
);

    logic [1:0]         byte_cnt;
    logic [7:0]         g_reg;
    logic [7:0]         r_reg;
    logic               push;
    logic               pop;
    logic               handshake;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_bits;

    assign push      = wr_en && !clear && (byte_cnt == BYTE_B);
    assign pix_valid = (fifo_level != '0);
    assign handshake = pix_valid && pix_ready;
    assign pix_data  = head_entry.pixel;

    assign push_entry.pixel = {g_reg, r_reg, wr_data};
    assign push_entry.latch = wr_latch;
`ifdef WS2812B_PIXEL_REPEAT_EN
    assign push_entry.rpt   = wr_repeat;
`endif
    assign head_entry = fifo_entry_t'(head_bits);

`ifdef WS2812B_PIXEL_REPEAT_EN
    logic [7:0] rpt_cnt;
    logic       last_show;

    // The entry leaves only on its final presentation; latch marks that one
    assign last_show = (rpt_cnt == head_entry.rpt);
    assign pop       = handshake && last_show;
    assign pix_latch = head_entry.latch && last_show;

    // Presentations already made of the current head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
        end else if (clear) begin
            rpt_cnt <= '0;
        end else if (handshake) begin
            rpt_cnt <= last_show ? 8'd0 : rpt_cnt + 8'd1;
        end
    end
`else
    assign pop       = handshake;
    assign pix_latch = head_entry.latch;
`endif

    // Byte assembler: G and R are held until B completes the pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= BYTE_G;
            g_reg    <= '0;
            r_reg    <= '0;
        end else if (clear) begin
            byte_cnt <= BYTE_G;
        end else if (wr_en) begin
            case (byte_cnt)
                BYTE_G: begin
                    g_reg    <= wr_data;
                    byte_cnt <= BYTE_R;
                end
                BYTE_R: begin
                    r_reg    <= wr_data;
                    byte_cnt <= BYTE_B;
                end
                default: byte_cnt <= BYTE_G;
            endcase
        end
    end

    // Sticky flag for a completed pixel that found no room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    ws2812b_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_bits),
        .level     (fifo_level),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ws2812b_pixel_fifo.sv
// Directed bench for ws2812b_pixel_fifo at DEPTH=4.
// Build with WS2812B_PIXEL_REPEAT_EN defined to include the repeat scenario.
module tb_ws2812b_pixel_fifo;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_latch;
    logic        clear;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_latch;
    logic        pix_ready;
    logic [2:0]  fifo_level;
    logic        fifo_full;
    logic        overflow;
`ifdef WS2812B_PIXEL_REPEAT_EN
    logic [7:0]  wr_repeat;
`endif

    int checks;
    int errors;

    ws2812b_pixel_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_latch   (wr_latch),
`ifdef WS2812B_PIXEL_REPEAT_EN
        .wr_repeat  (wr_repeat),
`endif
        .clear      (clear),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_latch  (pix_latch),
        .pix_ready  (pix_ready),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: inputs driven 1 time unit after an edge, sampled at the next edge
    task automatic send_byte(input logic [7:0] b, input logic lat, input logic rdy);
        wr_en     = 1'b1;
        wr_data   = b;
        wr_latch  = lat;
        pix_ready = rdy;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        wr_latch  = 1'b0;
        pix_ready = 1'b0;
    endtask

    task automatic send_pixel(input logic [23:0] p, input logic lat, input logic rdy_last);
        send_byte(p[23:16], 1'b0, 1'b0);
        send_byte(p[15:8],  1'b0, 1'b0);
        send_byte(p[7:0],   lat,  rdy_last);
    endtask

    task automatic pop_one();
        pix_ready = 1'b1;
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    logic [23:0] exp_q[4];

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        wr_latch  = 1'b0;
        clear     = 1'b0;
        pix_ready = 1'b0;
`ifdef WS2812B_PIXEL_REPEAT_EN
        wr_repeat = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(pix_data), 32'h0);
        check("rst_valid", 32'(pix_valid), 32'h0);
        check("rst_latch", 32'(pix_latch), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_full", 32'(fifo_full), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel with latch, then one handshake
        send_pixel(24'h123456, 1'b1, 1'b0);
        check("p1_valid", 32'(pix_valid), 32'h1);
        check("p1_data", 32'(pix_data), 32'h123456);
        check("p1_latch", 32'(pix_latch), 32'h1);
        check("p1_level", 32'(fifo_level), 32'h1);
        pop_one();
        check("p1_pop_level", 32'(fifo_level), 32'h0);
        check("p1_pop_valid", 32'(pix_valid), 32'h0);

        // Five pixels into four entries: the fifth is dropped
        send_pixel(24'h010203, 1'b0, 1'b0);
        send_pixel(24'h040506, 1'b0, 1'b0);
        send_pixel(24'h070809, 1'b0, 1'b0);
        send_pixel(24'h0A0B0C, 1'b1, 1'b0);
        check("ovf_pre", 32'(overflow), 32'h0);
        send_pixel(24'h0D0E0F, 1'b0, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'h4);
        check("ovf_full", 32'(fifo_full), 32'h1);
        check("ovf_flag", 32'(overflow), 32'h1);
        exp_q[0] = 24'h010203;
        exp_q[1] = 24'h040506;
        exp_q[2] = 24'h070809;
        exp_q[3] = 24'h0A0B0C;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_out%0d", i), 32'(pix_data), 32'(exp_q[i]));
            check($sformatf("ovf_lat%0d", i), 32'(pix_latch), (i == 3) ? 32'h1 : 32'h0);
            pop_one();
        end
        check("ovf_drained", 32'(fifo_level), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        pulse_clear();
        check("clr_ovf", 32'(overflow), 32'h0);

        // Push and pop in the same cycle while full
        send_pixel(24'h100001, 1'b0, 1'b0);
        send_pixel(24'h100002, 1'b0, 1'b0);
        send_pixel(24'h100003, 1'b0, 1'b0);
        send_pixel(24'h100004, 1'b0, 1'b0);
        send_pixel(24'hA1A2A3, 1'b0, 1'b1);
        check("pp_level", 32'(fifo_level), 32'h4);
        check("pp_full", 32'(fifo_full), 32'h1);
        check("pp_ovf", 32'(overflow), 32'h0);
        exp_q[0] = 24'h100002;
        exp_q[1] = 24'h100003;
        exp_q[2] = 24'h100004;
        exp_q[3] = 24'hA1A2A3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_out%0d", i), 32'(pix_data), 32'(exp_q[i]));
            pop_one();
        end
        check("pp_drained", 32'(fifo_level), 32'h0);

        // Ready while empty does not bypass: the pixel stays queued
        send_pixel(24'h556677, 1'b0, 1'b1);
        check("nobyp_level", 32'(fifo_level), 32'h1);
        check("nobyp_data", 32'(pix_data), 32'h556677);
        pop_one();

        // Clear mid-pixel discards the partial G/R
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        pulse_clear();
        check("clr_level", 32'(fifo_level), 32'h0);
        send_pixel(24'hAABBCC, 1'b0, 1'b0);
        check("clr_data", 32'(pix_data), 32'hAABBCC);
        check("clr_level1", 32'(fifo_level), 32'h1);

        // Clear with a concurrent write: the write is ignored
        clear = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h99;
        @(posedge clk);
        #1;
        clear = 1'b0;
        wr_en = 1'b0;
        check("clrwr_level", 32'(fifo_level), 32'h0);
        send_pixel(24'h314159, 1'b0, 1'b0);
        check("clrwr_data", 32'(pix_data), 32'h314159);
        pulse_clear();

        // Asynchronous reset with three entries and a partial pixel
        send_pixel(24'h111111, 1'b1, 1'b0);
        send_pixel(24'h222222, 1'b0, 1'b0);
        send_pixel(24'h333333, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        check("ar_pre_level", 32'(fifo_level), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_data", 32'(pix_data), 32'h0);
        check("ar_valid", 32'(pix_valid), 32'h0);
        check("ar_latch", 32'(pix_latch), 32'h0);
        check("ar_level", 32'(fifo_level), 32'h0);
        check("ar_full", 32'(fifo_full), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pixel(24'hDEADBE, 1'b0, 1'b0);
        check("ar_new_data", 32'(pix_data), 32'hDEADBE);
        check("ar_new_level", 32'(fifo_level), 32'h1);
        pop_one();

`ifdef WS2812B_PIXEL_REPEAT_EN
        // Head shown three times, latch only on the last showing
        wr_repeat = 8'd2;
        send_pixel(24'h00FF00, 1'b1, 1'b0);
        wr_repeat = 8'd0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rpt_data%0d", i), 32'(pix_data), 32'h00FF00);
            check($sformatf("rpt_latch%0d", i), 32'(pix_latch), (i == 2) ? 32'h1 : 32'h0);
            check($sformatf("rpt_level%0d", i), 32'(fifo_level), 32'h1);
            pop_one();
        end
        check("rpt_done", 32'(fifo_level), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
